// File: rtl/mbank_pkg.sv
// Shared types and helpers for the multi-bank request demux.
// Optional statistics build: define MBANK_DEMUX_STATS_EN.
package mbank_pkg;

  localparam int MBANK_MAX_BANKS = 16;
  localparam int STAT_W = 16;
  localparam int ERR_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } demux_state_e;

  function automatic logic [31:0] bank_idx(
    input logic [31:0] addr,
    input int          laddr_w
  );
    return addr >> laddr_w;
  endfunction

endpackage

// File: rtl/mbank_req_demux_if.sv
// Request bus between the AXI front-end, the demux and the banks.
// slave = demux view, master = driver/bank-model view.
interface mbank_req_demux_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32
);
  localparam int SEL_W   = $clog2(NUM_BANKS);
  localparam int LADDR_W = ADDR_W - SEL_W;
  localparam int STRB_W  = DATA_W / 8;

  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_addr;
  logic                 in_we;
  logic [DATA_W-1:0]    in_wdata;
  logic [STRB_W-1:0]    in_wstrb;
  logic [NUM_BANKS-1:0] out_valid;
  logic [NUM_BANKS-1:0] out_ready;
  logic [LADDR_W-1:0]   out_addr;
  logic                 out_we;
  logic [DATA_W-1:0]    out_wdata;
  logic [STRB_W-1:0]    out_wstrb;
  logic                 err_sel;

  modport slave (
    input  in_valid, in_addr, in_we, in_wdata, in_wstrb,
    input  out_ready,
    output in_ready,
    output out_valid, out_addr, out_we, out_wdata, out_wstrb,
    output err_sel
  );

  modport master (
    output in_valid, in_addr, in_we, in_wdata, in_wstrb,
    output out_ready,
    input  in_ready,
    input  out_valid, out_addr, out_we, out_wdata, out_wstrb,
    input  err_sel
  );

endinterface

// File: rtl/mbank_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Used only by the statistics build (MBANK_DEMUX_STATS_EN).
module mbank_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mbank_req_demux.sv
// Registered 1-to-NUM_BANKS request demux, one-entry output stage.
// Define MBANK_DEMUX_STATS_EN for per-bank handshake and error counters.
module mbank_req_demux
  import mbank_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  mbank_req_demux_if.slave bus
`ifdef MBANK_DEMUX_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [NUM_BANKS*STAT_W-1:0] stat_cnt,
  output logic [ERR_CNT_W-1:0]        err_cnt
`endif
);

  localparam int SEL_W   = $clog2(NUM_BANKS);
  localparam int LADDR_W = ADDR_W - SEL_W;
  localparam int STRB_W  = DATA_W / 8;

  demux_state_e         state_q, state_d;
  logic [NUM_BANKS-1:0] vld_q, vld_d;
  logic [NUM_BANKS-1:0] one;
  logic [LADDR_W-1:0]   addr_q;
  logic                 we_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic                 err_q;
  logic [31:0]          idx_w;
  logic [SEL_W-1:0]     idx;
  logic                 in_rng;
  logic                 drain;
  logic                 rdy;
  logic                 accept;
  logic                 load;

  assign idx_w  = bank_idx(32'(bus.in_addr), LADDR_W);
  assign in_rng = idx_w < 32'(NUM_BANKS);
  assign idx    = idx_w[SEL_W-1:0];
  assign one    = NUM_BANKS'(1) << idx;

  // vld_q is one-hot on the held bank, so this is out_ready[hold_sel]
  assign drain  = |(vld_q & bus.out_ready);
  assign rdy    = (state_q == EMPTY) || drain;
  assign accept = bus.in_valid && rdy;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept && in_rng) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (drain) begin
          if (accept && in_rng) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    vld_d = vld_q;
    if (load) begin
      vld_d = one;
    end else if (state_d == EMPTY) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      vld_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      err_q   <= accept && !in_rng;
      if (load) begin
        addr_q  <= bus.in_addr[LADDR_W-1:0];
        we_q    <= bus.in_we;
        wdata_q <= bus.in_wdata;
        wstrb_q <= bus.in_wstrb;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_we    = we_q;
  assign bus.out_wdata = wdata_q;
  assign bus.out_wstrb = wstrb_q;
  assign bus.err_sel   = err_q;

`ifdef MBANK_DEMUX_STATS_EN
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_stat
    mbank_sat_cnt #(.W(STAT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stat_clr),
      .inc   (vld_q[i] & bus.out_ready[i]),
      .cnt   (stat_cnt[i*STAT_W +: STAT_W])
    );
  end

  mbank_sat_cnt #(.W(ERR_CNT_W)) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (err_q),
    .cnt   (err_cnt)
  );
`endif

endmodule

// File: tb/tb_mbank_req_demux.sv
// Directed + random bench for mbank_req_demux (4-bank and 3-bank builds).
// Statistics checks are included when MBANK_DEMUX_STATS_EN is defined.
module tb_mbank_req_demux;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mbank_req_demux_if #(.NUM_BANKS(4)) b4 ();
  mbank_req_demux_if #(.NUM_BANKS(3)) b3 ();

`ifdef MBANK_DEMUX_STATS_EN
  logic        clr4, clr3;
  logic [63:0] sc4;
  logic [47:0] sc3;
  logic [7:0]  ec4, ec3;
`endif

  mbank_req_demux #(.NUM_BANKS(4)) d4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b4)
`ifdef MBANK_DEMUX_STATS_EN
    ,
    .stat_clr (clr4),
    .stat_cnt (sc4),
    .err_cnt  (ec4)
`endif
  );

  mbank_req_demux #(.NUM_BANKS(3)) d3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b3)
`ifdef MBANK_DEMUX_STATS_EN
    ,
    .stat_clr (clr3),
    .stat_cnt (sc3),
    .err_cnt  (ec3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  req_t held[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected 4-bank output from the request alone: bank = addr / 1024
  function automatic logic [63:0] exp_out(input req_t r);
    int unsigned b;
    logic [3:0]  v;
    b = r.a / 1024;
    v = 4'(1 << b);
    return {13'b0, v, 10'(r.a % 1024), r.we, r.d, r.s};
  endfunction

  function automatic logic [63:0] obs4();
    return {13'b0, b4.out_valid, b4.out_addr, b4.out_we,
            b4.out_wdata, b4.out_wstrb};
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.a  = 12'($urandom);
    r.we = 1'($urandom);
    r.d  = $urandom;
    r.s  = 4'($urandom);
    return r;
  endfunction

  // one clock of the 4-bank DUT against a one-slot holding model
  task automatic cyc4(input logic iv, input req_t r, input logic [3:0] rdy);
    logic er;
    b4.in_valid  = iv;
    b4.in_addr   = r.a;
    b4.in_we     = r.we;
    b4.in_wdata  = r.d;
    b4.in_wstrb  = r.s;
    b4.out_ready = rdy;
    er = (held.size() == 0) || rdy[held[0].a / 1024];
    #1 chk("in_ready4", 64'(b4.in_ready), 64'(er));
    @(posedge clk);
    #1;
    if (held.size() != 0 && rdy[held[0].a / 1024]) void'(held.pop_front());
    if (iv && er) held.push_back(r);
    if (held.size() == 0) chk("idle4", 64'(b4.out_valid), 64'd0);
    else chk("out4", obs4(), exp_out(held[0]));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot4", 64'($onehot0(b4.out_valid)), 64'd1);
      chk("onehot3", 64'($onehot0(b3.out_valid)), 64'd1);
    end
  end

  initial begin
    req_t r;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    b4.in_valid = 0; b4.in_addr = 0; b4.in_we = 0;
    b4.in_wdata = 0; b4.in_wstrb = 0; b4.out_ready = 0;
    b3.in_valid = 0; b3.in_addr = 0; b3.in_we = 0;
    b3.in_wdata = 0; b3.in_wstrb = 0; b3.out_ready = 0;
`ifdef MBANK_DEMUX_STATS_EN
    clr4 = 0;
    clr3 = 0;
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", 64'(b4.out_valid), 64'd0);
    chk("rst_ready", 64'(b4.in_ready), 64'd1);
    chk("rst_err", 64'(b4.err_sel), 64'd0);
    chk("rst_addr", 64'(b4.out_addr), 64'd0);
    chk("rst_data", 64'(b4.out_wdata), 64'd0);
    chk("rst_we", 64'({b4.out_we, b4.out_wstrb}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // route
    r = '{a: 12'h8A4, we: 1'b1, d: 32'hDEADBEEF, s: 4'hF};
    cyc4(1'b1, r, 4'b0000);
    chk("route_valid", 64'(b4.out_valid), 64'(4'b0100));
    chk("route_addr", 64'(b4.out_addr), 64'(10'h0A4));
    chk("route_data", 64'(b4.out_wdata), 64'(32'hDEADBEEF));

    // backpressure: bank 2 stalled while a bank-1 request waits
    r = '{a: 12'h433, we: 1'b0, d: 32'h12345678, s: 4'h3};
    repeat (6) cyc4(1'b1, r, 4'b1011);
    cyc4(1'b1, r, 4'b0100);
    chk("bp_reload", 64'(b4.out_valid), 64'(4'b0010));
    chk("bp_addr", 64'(b4.out_addr), 64'(10'h033));
    cyc4(1'b0, r, 4'b0010);
    chk("bp_drained", 64'(b4.out_valid), 64'd0);

    // streaming, all banks ready: every cycle must accept and present
    for (int i = 0; i < 64; i++) begin
      cyc4(1'b1, rnd_req(), 4'b1111);
      chk("stream_nobubble", 64'(b4.out_valid != 0), 64'd1);
    end
    cyc4(1'b0, rnd_req(), 4'b1111);

    // random valid and random per-bank ready
    for (int i = 0; i < 200; i++) begin
      cyc4(1'($urandom_range(0, 3) != 0), rnd_req(), 4'($urandom));
    end

    // async reset while FULL and stalled
    r = '{a: 12'hC10, we: 1'b1, d: 32'hCAFEF00D, s: 4'h5};
    cyc4(1'b0, r, 4'b1111);
    cyc4(1'b1, r, 4'b0000);
    chk("ar_full", 64'(b4.out_valid), 64'(4'b1000));
    b4.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(b4.out_valid), 64'd0);
    chk("ar_addr", 64'(b4.out_addr), 64'd0);
    held.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    r = '{a: 12'h1FF, we: 1'b0, d: 32'h0BADC0DE, s: 4'h9};
    cyc4(1'b1, r, 4'b0000);
    chk("ar_route", 64'(b4.out_valid), 64'(4'b0001));
    cyc4(1'b0, r, 4'b0001);

    // out-of-range on the 3-bank build
    b3.in_valid = 1'b1;
    b3.in_addr  = 12'hC55;
    #1 chk("oor_ready", 64'(b3.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b3.in_valid = 1'b0;
    chk("oor_err", 64'(b3.err_sel), 64'd1);
    chk("oor_valid", 64'(b3.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("oor_pulse", 64'(b3.err_sel), 64'd0);
    b3.in_valid = 1'b1;
    b3.in_addr  = 12'h155;
    @(posedge clk);
    #1;
    chk("oor_load", 64'(b3.out_valid), 64'(3'b001));
    chk("oor_laddr", 64'(b3.out_addr), 64'(10'h155));
    b3.out_ready = 3'b001;
    b3.in_addr   = 12'hFFF;
    #1 chk("oor_ready2", 64'(b3.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b3.in_valid = 1'b0;
    chk("oor_empty", 64'(b3.out_valid), 64'd0);
    chk("oor_err2", 64'(b3.err_sel), 64'd1);

`ifdef MBANK_DEMUX_STATS_EN
    @(posedge clk);
    #1;
    chk("errcnt3", 64'(ec3), 64'd2);
    clr4 = 1'b1;
    @(posedge clk);
    #1 clr4 = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_addr   = 12'h010;
    b4.out_ready = 4'b1111;
    repeat (70001) @(posedge clk);
    #1;
    chk("stat_sat", 64'(sc4[15:0]), 64'hFFFF);
    chk("stat_b1", 64'(sc4[31:16]), 64'd0);
    clr4 = 1'b1;
    @(posedge clk);
    #1;
    chk("stat_clr", 64'(sc4[15:0]), 64'd0);
    clr4 = 1'b0;
    b4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stat_after", 64'(sc4[15:0]), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
